// File: rtl/instr_adr_stage_bp_pkg.sv
// Shared types and constants for the registered next-instruction-address stage and its BTB.
package instr_adr_stage_bp_pkg;

  localparam int unsigned WordLengthDef = 32;
  localparam int unsigned InstrBytesDef = 4;

  localparam logic [1:0] CtrWeakTaken = 2'd2;
  localparam logic [1:0] CtrMax       = 2'd3;

  typedef enum logic [0:0] {
    StReset = 1'b0,
    StRun   = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/instr_adr_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the fetch offset; updates from EX are written on clk.
module instr_adr_btb
  import instr_adr_stage_bp_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WordLengthDef,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned INSTR_BYTES = InstrBytesDef
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WORD_LENGTH-1:0] lookup_pc_i,
  output logic                   pred_taken_o,
  output logic [WORD_LENGTH-1:0] pred_target_o,
  input  logic                   upd_valid_i,
  input  logic [WORD_LENGTH-1:0] upd_pc_i,
  input  logic [WORD_LENGTH-1:0] upd_target_i,
  input  logic                   upd_taken_i
);

  localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned OfsW = $clog2(INSTR_BYTES);
  localparam int unsigned TagW = WORD_LENGTH - OfsW - IdxW;

  typedef struct packed {
    logic                   valid;
    logic [TagW-1:0]        tag;
    logic [WORD_LENGTH-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  btb_entry_t mem_q [BTB_ENTRIES];

  logic [IdxW-1:0] lk_idx, upd_idx;
  logic [TagW-1:0] lk_tag, upd_tag;
  btb_entry_t      lk_entry, upd_old, upd_new;
  logic            upd_we;

  assign lk_idx  = lookup_pc_i[OfsW +: IdxW];
  assign lk_tag  = lookup_pc_i[WORD_LENGTH-1 -: TagW];
  assign upd_idx = upd_pc_i[OfsW +: IdxW];
  assign upd_tag = upd_pc_i[WORD_LENGTH-1 -: TagW];

  // Byte-offset bits never select or tag an entry.
  if (OfsW > 0) begin : g_ofs
    logic unused_ofs;
    assign unused_ofs = ^{lookup_pc_i[OfsW-1:0], upd_pc_i[OfsW-1:0]};
  end

  always_comb begin
    lk_entry      = mem_q[lk_idx];
    pred_taken_o  = lk_entry.valid && (lk_entry.tag == lk_tag) && (lk_entry.ctr >= CtrWeakTaken);
    pred_target_o = lk_entry.target;
  end

  always_comb begin
    upd_old = mem_q[upd_idx];
    upd_new = upd_old;
    upd_we  = 1'b0;
    if (upd_valid_i) begin
      if (upd_old.valid && (upd_old.tag == upd_tag)) begin
        upd_we = 1'b1;
        if (upd_taken_i) begin
          upd_new.ctr    = (upd_old.ctr == CtrMax) ? CtrMax : upd_old.ctr + 2'd1;
          upd_new.target = upd_target_i;
        end else begin
          upd_new.ctr = (upd_old.ctr == 2'd0) ? 2'd0 : upd_old.ctr - 2'd1;
        end
      end else if (upd_taken_i) begin
        upd_we         = 1'b1;
        upd_new.valid  = 1'b1;
        upd_new.tag    = upd_tag;
        upd_new.target = upd_target_i;
        upd_new.ctr    = CtrWeakTaken;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (upd_we) begin
      mem_q[upd_idx] <= upd_new;
    end
  end

endmodule

// File: rtl/instr_adr_stage_bp.sv
// Registered next-instruction-address generator: EX/OF/DF redirects, stall hold,
// BTB-predicted targets and sequential increment, in that priority.
module instr_adr_stage_bp
  import instr_adr_stage_bp_pkg::*;
#(
  parameter int unsigned WORD_LENGTH   = WordLengthDef,
  parameter int unsigned BTB_ENTRIES   = 16,
  parameter int unsigned INSTR_BYTES   = InstrBytesDef,
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE0 = '0,
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE1 = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inExRedirect,
  input  logic [WORD_LENGTH-1:0] inExPstate0,
  input  logic [WORD_LENGTH-1:0] inExPstate1,
  input  logic                   inOfRedirect,
  input  logic [WORD_LENGTH-1:0] inOfPstate0,
  input  logic [WORD_LENGTH-1:0] inOfPstate1,
  input  logic                   inDfRedirect,
  input  logic [WORD_LENGTH-1:0] inDfPstate0,
  input  logic [WORD_LENGTH-1:0] inDfPstate1,
  input  logic                   inStall,
  input  logic                   inBtbUpdValid,
  input  logic [WORD_LENGTH-1:0] inBtbUpdPc,
  input  logic [WORD_LENGTH-1:0] inBtbUpdTarget,
  input  logic                   inBtbUpdTaken,
  output logic                   outValid,
  output logic [WORD_LENGTH-1:0] outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
  output logic                   outPredTaken
);

  localparam logic [WORD_LENGTH-1:0] InstrInc = WORD_LENGTH'(INSTR_BYTES);

  fsm_state_e             state_q, state_d;
  logic [WORD_LENGTH-1:0] pstate0_q, pstate0_d;
  logic [WORD_LENGTH-1:0] pstate1_q, pstate1_d;
  logic                   pred_q, pred_d;

  logic                   btb_pred_taken;
  logic [WORD_LENGTH-1:0] btb_pred_target;

  instr_adr_btb #(
    .WORD_LENGTH (WORD_LENGTH),
    .BTB_ENTRIES (BTB_ENTRIES),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_btb (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_pc_i   (pstate1_q),
    .pred_taken_o  (btb_pred_taken),
    .pred_target_o (btb_pred_target),
    .upd_valid_i   (inBtbUpdValid),
    .upd_pc_i      (inBtbUpdPc),
    .upd_target_i  (inBtbUpdTarget),
    .upd_taken_i   (inBtbUpdTaken)
  );

  always_comb begin
    state_d   = state_q;
    pstate0_d = pstate0_q;
    pstate1_d = pstate1_q;
    pred_d    = pred_q;
    unique case (state_q)
      StReset: begin
        // Leave reset without touching the address so the reset vector is fetched first.
        state_d = StRun;
      end
      StRun: begin
        if (inExRedirect) begin
          pstate0_d = inExPstate0;
          pstate1_d = inExPstate1;
          pred_d    = 1'b0;
        end else if (inOfRedirect) begin
          pstate0_d = inOfPstate0;
          pstate1_d = inOfPstate1;
          pred_d    = 1'b0;
        end else if (inDfRedirect) begin
          pstate0_d = inDfPstate0;
          pstate1_d = inDfPstate1;
          pred_d    = 1'b0;
        end else if (inStall) begin
          pred_d = pred_q;
        end else if (btb_pred_taken) begin
          pstate1_d = btb_pred_target;
          pred_d    = 1'b1;
        end else begin
          pstate1_d = pstate1_q + InstrInc;
          pred_d    = 1'b0;
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReset;
      pstate0_q <= RESET_PSTATE0;
      pstate1_q <= RESET_PSTATE1;
      pred_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pstate0_q <= pstate0_d;
      pstate1_q <= pstate1_d;
      pred_q    <= pred_d;
    end
  end

  assign outValid     = (state_q == StRun);
  assign outPstate0   = pstate0_q;
  assign outPstate1   = pstate1_q;
  assign outPredTaken = pred_q;

endmodule

// File: tb/tb_instr_adr_stage_bp.sv
// Directed self-checking bench for instr_adr_stage_bp with hand-computed expectations.
module tb_instr_adr_stage_bp;

  localparam logic [31:0] RstP0 = 32'h0000_005A;
  localparam logic [31:0] RstP1 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_r = 1'b0, of_r = 1'b0, df_r = 1'b0, stall = 1'b0;
  logic [31:0] ex_p0 = '0, ex_p1 = '0, of_p0 = '0, of_p1 = '0, df_p0 = '0, df_p1 = '0;
  logic        upd_v = 1'b0, upd_t = 1'b0;
  logic [31:0] upd_pc = '0, upd_tg = '0;
  logic        valid, pred;
  logic [31:0] p0, p1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_adr_stage_bp #(
    .WORD_LENGTH   (32),
    .BTB_ENTRIES   (16),
    .INSTR_BYTES   (4),
    .RESET_PSTATE0 (RstP0),
    .RESET_PSTATE1 (RstP1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inExRedirect   (ex_r),
    .inExPstate0    (ex_p0),
    .inExPstate1    (ex_p1),
    .inOfRedirect   (of_r),
    .inOfPstate0    (of_p0),
    .inOfPstate1    (of_p1),
    .inDfRedirect   (df_r),
    .inDfPstate0    (df_p0),
    .inDfPstate1    (df_p1),
    .inStall        (stall),
    .inBtbUpdValid  (upd_v),
    .inBtbUpdPc     (upd_pc),
    .inBtbUpdTarget (upd_tg),
    .inBtbUpdTaken  (upd_t),
    .outValid       (valid),
    .outPstate0     (p0),
    .outPstate1     (p1),
    .outPredTaken   (pred)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] e0,
                         input logic [31:0] e1, input logic ep);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, ".p0"}, p0, e0);
    chk({tag, ".p1"}, p1, e1);
    chk({tag, ".pred"}, {31'b0, pred}, {31'b0, ep});
  endtask

  task automatic ex_to(input logic [31:0] np0, input logic [31:0] np1);
    ex_r = 1'b1; ex_p0 = np0; ex_p1 = np1;
    step();
    ex_r = 1'b0;
  endtask

  initial begin
    // Reset and release: one invalid cycle at 0x0, then sequential fetch.
    #12;
    chk_out("rst_hold", 1'b0, RstP0, RstP1, 1'b0);
    step();
    rst = 1'b0;
    chk_out("rst_rel", 1'b0, RstP0, 32'h0, 1'b0);
    step();
    chk_out("run0", 1'b1, RstP0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_out("seq", 1'b1, RstP0, 32'(4 * i), 1'b0);
    end

    // Stall holds 0x10 for three cycles, then resumes at 0x14.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", p1, 32'h10);
    end
    stall = 1'b0;
    step();
    chk("stall_rel", p1, 32'h14);

    // EX beats OF and stall.
    ex_r = 1'b1; ex_p0 = 32'h77; ex_p1 = 32'h2000;
    of_r = 1'b1; of_p0 = 32'h99; of_p1 = 32'h3000;
    stall = 1'b1;
    step();
    ex_r = 1'b0; of_r = 1'b0; stall = 1'b0;
    chk_out("ex_prio", 1'b1, 32'h77, 32'h2000, 1'b0);

    // OF beats DF.
    of_r = 1'b1; of_p0 = 32'h88; of_p1 = 32'h3000;
    df_r = 1'b1; df_p0 = 32'h66; df_p1 = 32'h4000;
    step();
    of_r = 1'b0;
    chk_out("of_prio", 1'b1, 32'h88, 32'h3000, 1'b0);
    step();
    df_r = 1'b0;
    chk_out("df_only", 1'b1, 32'h66, 32'h4000, 1'b0);

    // Two taken updates for pc 0x40 -> 0x100 (allocate at ctr 2, then 3).
    upd_v = 1'b1; upd_t = 1'b1; upd_pc = 32'h40; upd_tg = 32'h100;
    step();
    step();
    upd_v = 1'b0;
    ex_to(32'h77, 32'h38);
    chk_out("btb_38", 1'b1, 32'h77, 32'h38, 1'b0);
    step();
    chk("btb_3c", p1, 32'h3C);
    step();
    chk_out("btb_40", 1'b1, 32'h77, 32'h40, 1'b0);
    step();
    chk_out("btb_pred", 1'b1, 32'h77, 32'h100, 1'b1);
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk_out("pred_stall", 1'b1, 32'h77, 32'h100, 1'b1);
    step();
    chk_out("after_pred", 1'b1, 32'h77, 32'h104, 1'b0);

    // Two not-taken updates: ctr 3 -> 2 -> 1, prediction drops.
    upd_v = 1'b1; upd_t = 1'b0; upd_pc = 32'h40;
    step();
    step();
    upd_v = 1'b0;
    ex_to(32'h77, 32'h3C);
    step();
    chk("nt_40", p1, 32'h40);
    step();
    chk_out("nt_44", 1'b1, 32'h77, 32'h44, 1'b0);

    // Sequential wrap at the top of the offset space.
    ex_to(32'h77, 32'hFFFF_FFFC);
    chk("wrap_pre", p1, 32'hFFFF_FFFC);
    step();
    chk_out("wrap", 1'b1, 32'h77, 32'h0, 1'b0);

    // Async reset while a taken allocate for pc 0x80 is pending.
    upd_v = 1'b1; upd_t = 1'b1; upd_pc = 32'h80; upd_tg = 32'h200;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, RstP0, RstP1, 1'b0);
    step();
    upd_v = 1'b0;
    rst = 1'b0;
    step();
    chk_out("rst2_run", 1'b1, RstP0, 32'h0, 1'b0);
    ex_to(RstP0, 32'h7C);
    step();
    chk("noalloc_80", p1, 32'h80);
    step();
    chk_out("noalloc_84", 1'b1, RstP0, 32'h84, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
